mux_bus_slave: RTL and testbench

Register-file slave on the CPU's multiplexed address/data bus, directly downstream of the CPU core's ALE / En / Rw strobes. It latches an address on ALE and serves a write or a wait-stated read during the following En pulse. It counts completed transfers and flags protocol violations. A side port lets the display logic peek any register without disturbing bus traffic.

---
 rtl/mux_bus_slave.sv | 188 ++++++++++++++++++
 tb/tb_mux_bus_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_bus_slave.sv
// mux_bus_slave: register-file slave on a multiplexed address/data bus.
// Latches an address on ALE, then serves a write or a wait-stated read
// during the following En pulse. Counts completed transfers, flags
// protocol violations, and exposes a combinational peek port.
module mux_bus_slave #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned READ_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ale,
    input  logic              en,
    input  logic              rw,
    input  logic [DATA_W-1:0] ad_in,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              ready,
    output logic              err,
    input  logic              err_clr,
    output logic [7:0]        xfer_cnt,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam logic [2:0]  WAIT_INIT = 3'(READ_WAIT);
    localparam logic        NO_WAIT   = (READ_WAIT == 0);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RWAIT,
        RDATA,
        HOLD
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [2:0]        wcnt;

    // Per-cycle action strobes decoded by the FSM
    logic latch_addr;
    logic do_write;
    logic start_read;
    logic enter_rdata;
    logic wcnt_dec;
    logic finish_read;
    logic abort_read;
    logic err_set;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and action decode; ALE outside IDLE/ARMED only raises err
    always_comb begin
        state_n     = state;
        latch_addr  = 1'b0;
        do_write    = 1'b0;
        start_read  = 1'b0;
        enter_rdata = 1'b0;
        wcnt_dec    = 1'b0;
        finish_read = 1'b0;
        abort_read  = 1'b0;
        err_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    err_set = 1'b1;
                    state_n = HOLD;
                end else if (ale) begin
                    latch_addr = 1'b1;
                    state_n    = ARMED;
                end
            end
            ARMED: begin
                if (en && ale) begin
                    err_set = 1'b1;
                    state_n = HOLD;
                end else if (en) begin
                    if (rw) begin
                        start_read = 1'b1;
                        state_n    = NO_WAIT ? RDATA : RWAIT;
                    end else begin
                        do_write = 1'b1;
                        state_n  = HOLD;
                    end
                end else if (ale) begin
                    latch_addr = 1'b1;
                end
            end
            RWAIT: begin
                if (ale) begin
                    err_set = 1'b1;
                end
                if (!en) begin
                    err_set    = 1'b1;
                    abort_read = 1'b1;
                    state_n    = IDLE;
                end else if (wcnt == 3'd1) begin
                    enter_rdata = 1'b1;
                    state_n     = RDATA;
                end else begin
                    wcnt_dec = 1'b1;
                end
            end
            RDATA: begin
                if (ale) begin
                    err_set = 1'b1;
                end
                if (!en) begin
                    finish_read = 1'b1;
                    state_n     = IDLE;
                end
            end
            HOLD: begin
                if (ale) begin
                    err_set = 1'b1;
                end
                if (!en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Address latch, register file and read-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            wcnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (latch_addr) begin
                addr <= ad_in[ADDR_W-1:0];
            end
            if (do_write) begin
                mem[addr] <= ad_in;
            end
            if (start_read) begin
                wcnt <= WAIT_INIT;
            end else if (wcnt_dec) begin
                wcnt <= wcnt - 3'd1;
            end
        end
    end

    // Registered bus outputs, transfer counter and sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_out   <= '0;
            ad_oe    <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (start_read) begin
                ad_out <= mem[addr];
                ad_oe  <= 1'b1;
                ready  <= NO_WAIT;
            end else if (enter_rdata) begin
                ready <= 1'b1;
            end else if (finish_read || abort_read) begin
                ad_out <= '0;
                ad_oe  <= 1'b0;
                ready  <= 1'b0;
            end
            if (do_write || finish_read) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            err <= err_set | (err & ~err_clr);
        end
    end

    assign dbg_data = mem[dbg_sel];

endmodule

// File: tb/tb_mux_bus_slave.sv
// Self-checking bench for mux_bus_slave: randomized bus transfers against a
// transaction-level model; read data is checked through a scoreboard queue.
`timescale 1ns/100ps
module tb_mux_bus_slave;

    localparam int RW = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ale, en, rw, err_clr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, ready, err;
    logic [7:0] xfer_cnt;
    logic [3:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [7:0] mdl [16];
    int         mdl_cnt;
    logic       mdl_err;
    logic [7:0] sb [$];

    mux_bus_slave #(.ADDR_W(4), .DATA_W(8), .READ_WAIT(RW)) dut (
        .clk(clk), .rst(rst), .ale(ale), .en(en), .rw(rw), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .ready(ready), .err(err),
        .err_clr(err_clr), .xfer_cnt(xfer_cnt), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
        mdl_cnt = 0;
        mdl_err = 1'b0;
        sb.delete();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_cnt"}, {24'h0, xfer_cnt}, 32'(mdl_cnt % 256));
        check({tag, "_err"}, {31'h0, err}, {31'h0, mdl_err});
    endtask

    task automatic peek(input logic [3:0] a, input string tag);
        dbg_sel = a;
        #0.1;
        check({tag, "_dbg"}, {24'h0, dbg_data}, {24'h0, mdl[a]});
    endtask

    // Monitor: pops an expectation when read data becomes valid
    logic ready_q = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ready && !ready_q) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ready", 32'd1, 32'd0);
                end else begin
                    check("sb_read_data", {24'h0, ad_out}, {24'h0, sb.pop_front()});
                end
            end
            if (!ad_oe) check("ad_out_zero_when_idle", {24'h0, ad_out}, 32'h0);
        end
        ready_q <= ready & ~rst;
    end

    task automatic ale_cycle(input logic [3:0] a);
        @(negedge clk);
        ale = 1'b1; en = 1'b0; ad_in = {4'h0, a};
    endtask

    task automatic write_xfer(input logic [3:0] a, input logic [7:0] d);
        ale_cycle(a);
        @(negedge clk);
        ale = 1'b0; en = 1'b1; rw = 1'b0; ad_in = d;
        mdl[a] = d;
        mdl_cnt++;
        @(negedge clk);
        check("wr_oe_low", {31'h0, ad_oe}, 32'h0);
        check_status("wr");
        peek(a, "wr");
        en = 1'b0;
    endtask

    // hold = number of cycles en is sampled high; hold <= RW aborts
    task automatic read_xfer(input logic [3:0] a, input int hold);
        ale_cycle(a);
        @(negedge clk);
        ale = 1'b0; en = 1'b1; rw = 1'b1; ad_in = $urandom;
        if (hold > RW) sb.push_back(mdl[a]);
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            check("rd_oe", {31'h0, ad_oe}, 32'h1);
            check("rd_ready", {31'h0, ready}, (i - 1 >= RW) ? 32'h1 : 32'h0);
            if (i == hold) en = 1'b0;
            else rw = 1'($urandom);
        end
        if (hold > RW) mdl_cnt++;
        else mdl_err = 1'b1;
        @(negedge clk);
        check("rd_end_oe", {31'h0, ad_oe}, 32'h0);
        check("rd_end_ready", {31'h0, ready}, 32'h0);
        check_status("rd");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ad_out"}, {24'h0, ad_out}, 32'h0);
        check({tag, "_oe"}, {31'h0, ad_oe}, 32'h0);
        check({tag, "_ready"}, {31'h0, ready}, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
        check({tag, "_cnt"}, {24'h0, xfer_cnt}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #0.1;
            check({tag, "_mem"}, {24'h0, dbg_data}, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ale = 1'b0; en = 1'b0; rw = 1'b0; err_clr = 1'b0;
        ad_in = '0; dbg_sel = '0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read-back
        write_xfer(4'h3, 8'hA5);
        write_xfer(4'h7, 8'h5A);
        read_xfer(4'h7, RW + 2);

        // En with no preceding ALE
        @(negedge clk);
        en = 1'b1; rw = 1'b0; ad_in = 8'hEE;
        mdl_err = 1'b1;
        @(negedge clk);
        check_status("noale");
        peek(4'h3, "noale");
        en = 1'b0;
        @(negedge clk);
        err_clr = 1'b1;
        mdl_err = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        check_status("clr");
        // err_clr coinciding with a violation: set wins
        err_clr = 1'b1; en = 1'b1;
        mdl_err = 1'b1;
        @(negedge clk);
        check_status("clr_vs_set");
        err_clr = 1'b0; en = 1'b0;
        @(negedge clk);
        check_status("sticky");

        // ALE and En together while armed
        ale_cycle(4'h5);
        @(negedge clk);
        ale = 1'b1; en = 1'b1; rw = 1'b0; ad_in = 8'h0C;
        @(negedge clk);
        check_status("ale_en");
        peek(4'h5, "ale_en");
        peek(4'hC, "ale_en");
        ale = 1'b0; en = 1'b0;
        @(negedge clk);
        err_clr = 1'b1; mdl_err = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;

        // Read aborted during the wait phase
        read_xfer(4'h7, RW);

        // Last ALE wins
        ale_cycle(4'h2);
        write_xfer(4'h9, 8'h11);
        peek(4'h2, "two_ale");

        @(negedge clk);
        err_clr = 1'b1; mdl_err = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;

        // Randomized traffic, long enough for xfer_cnt to wrap
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) write_xfer(a, 8'($urandom));
            else read_xfer(a, $urandom_range(1, RW + 3));
            peek(4'($urandom_range(0, 15)), "rand");
        end
        check("total_cnt_wrapped", {31'h0, 1'(mdl_cnt >= 256)}, 32'h1);

        // Reset in the middle of a read data phase
        write_xfer(4'h4, 8'h77);
        ale_cycle(4'h4);
        @(negedge clk);
        ale = 1'b0; en = 1'b1; rw = 1'b1;
        sb.push_back(mdl[4'h4]);
        for (int i = 0; i <= RW; i++) @(negedge clk);
        check("pre_rst_ready", {31'h0, ready}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        en = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        write_xfer(4'h1, 8'h3C);
        read_xfer(4'h1, RW + 1);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
